// File: rtl/noc_output_arbiter.sv
// Wormhole switch allocator for one NoC output port.
// Round-robin head arbitration, packet lock, registered output link.
module noc_output_arbiter #(
  parameter int N         = 5,
  parameter int DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in_valid,
  input  logic [N-1:0]           in_head,
  input  logic [N-1:0]           in_tail,
  input  logic [N*DataWidth-1:0] in_data,
  output logic [N-1:0]           in_ready,
  output logic [N-1:0]           grant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DataWidth-1:0]   out_data,
  output logic                   out_head,
  output logic                   out_tail
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        lock_q, lock_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 out_head_q, out_head_d;
  logic                 out_tail_q, out_tail_d;

  logic [N-1:0]         req;
  logic [PW-1:0]        pick;
  logic                 found;
  logic                 can_load;
  logic                 xfer;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_head;
  logic                 sel_tail;
  int                   idx;
  int                   nxt;

  assign can_load = !out_valid_q | out_ready;
  assign req      = in_valid & in_head;

  // Winner select: locked input, else first head at/after rr_q.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    if (state_q == LOCKED) begin
      pick  = lock_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found = 1'b1;
          pick  = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found && rst_n) grant = N'(1) << pick;
  end

  assign in_ready = grant & {N{can_load}};
  assign xfer     = |(in_ready & in_valid);

  assign sel_data = in_data[int'(pick)*DataWidth +: DataWidth];
  assign sel_head = in_head[pick];
  assign sel_tail = in_tail[pick];

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_head_d  = out_head_q;
    out_tail_d  = out_tail_q;
    nxt         = int'(pick) + 1;
    if (nxt >= N) nxt = 0;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_head_d  = sel_head;
      out_tail_d  = sel_tail;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          rr_d = PW'(nxt);
          if (!sel_tail) begin
            state_d = LOCKED;
            lock_d  = pick;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_head_q  <= out_head_d;
      out_tail_q  <= out_tail_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_head  = out_head_q;
  assign out_tail  = out_tail_q;

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Per-output-port wormhole switch allocator and output register for the NoC router. It arbitrates among N input ports competing for one output port and locks the winner for a whole packet (head to tail flit). It drives a one-hot grant vector that serves directly as the select of the downstream one-hot crossbar mux, and it registers the selected flit onto the output link with a valid/ready handshake.

## Interface
- N, 5, number of competing input ports (1..16); grant is one-hot over N.
- DataWidth, 32, flit payload width.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  N  per-input flit valid.
- in_head  in  N  per-input head-flit marker, qualified by in_valid.
- in_tail  in  N  per-input tail-flit marker; head&tail = single-flit packet.
- in_data  in  N x DataWidth  packed per-input payload, index i = input i.
- in_ready  out  N  per-input accept; at most one bit set per cycle.
- grant  out  N  one-hot select of the current winner, all-zero when none; crossbar mux select.
- out_valid  out  1  registered output flit valid.
- out_ready  in  1  downstream accept.
- out_data  out  DataWidth  registered payload.
- out_head  out  1  registered head marker.
- out_tail  out  1  registered tail marker.

## Operation
- State: IDLE, LOCKED. Plus lock_idx (winner index), rr_ptr (0..N-1), and the output register.
- can_load = !out_valid | out_ready. Input i transfers when in_valid[i] & in_ready[i].
- IDLE: req[i] = in_valid[i] & in_head[i]. Round-robin pick: first set req starting at rr_ptr, ascending, wrapping N-1 -> 0. grant = one-hot(pick), or 0 if no req. Non-head flits in IDLE are never granted.
- in_ready = grant & {N{can_load}}.
- Head transfer in IDLE: rr_ptr <= (pick+1) mod N. If in_tail is clear, go to LOCKED with lock_idx <= pick. If in_tail is set (single-flit packet), stay IDLE.
- LOCKED: grant = one-hot(lock_idx) unconditionally; other inputs get in_ready=0. A transfer with in_tail=1 returns to IDLE. A gap (in_valid[lock_idx]=0) keeps the lock and inserts a bubble. Head bits seen while LOCKED are forwarded as data and not checked.
- rr_ptr updates only on a head transfer, never in LOCKED.
- Output register loads {in_data, in_head, in_tail} of the granted input on a transfer. out_valid <= 1 on a transfer; out_valid <= 0 when out_ready & no transfer.
- N=1: rr_ptr is constant 0; grant = in_valid[0]&in_head[0] in IDLE.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, rr_ptr=0, lock_idx=0, out_valid=0, out_data=0, out_head=0, out_tail=0. grant and in_ready are combinational, so they are 0 while rst_n is low.
- Asserting reset mid-packet drops the lock and any held flit; there is no recovery.
- Latency: input transfer in cycle t -> out_valid/out_data in cycle t+1.
- Throughput: 1 flit/cycle while out_ready=1. Back-to-back packets from different inputs need no idle cycle: a tail in cycle t lets a new head win in cycle t+1.
- Backpressure: out_valid=1 & out_ready=0 -> in_ready=0 and the output register holds stable. grant stays asserted, so the mux select is stable.
- Simultaneous out_ready & new transfer: the register is overwritten and out_valid stays 1.
- grant/in_ready depend combinationally on in_valid, in_head, state, rr_ptr and out_ready. There is no combinational path from in_data.

## Test plan
- Single requester (N=5): input 2 sends head/body/tail with data 0xA0,0xA1,0xA2 and out_ready=1. Required: grant=5'b00100 for 3 cycles, out_data=0xA0,0xA1,0xA2 in cycles t+1..t+3, out_tail on the last flit, rr_ptr=3 afterwards.
- Round-robin fairness: inputs 0,1,4 each send continuous single-flit packets (head&tail) and rr_ptr=0. Required grant order: 0,1,4,0,1,4; one flit out per cycle.
- Lock hold: input 1 sends a 4-flit packet with a 2-cycle valid gap after flit 2, while input 3 requests a head the whole time. Required: grant stays 5'b00010 through the gap, out_valid drops for 2 cycles, and input 3 gets its grant in the cycle after input 1's tail transfers.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 and out_data=0x55. Required: in_ready=0, out_data holds 0x55 and grant is stable. out_ready rises -> the next flit appears the following cycle with no loss or duplication.
- Non-head ignored: in IDLE, input 0 asserts valid with in_head=0. Required: grant=0 and in_ready=0 until a head arrives.
- Reset mid-packet: drop rst_n during LOCKED on input 4 with out_valid=1. Required: out_valid=0, grant=0 and state IDLE immediately. After release, input 0's head wins since rr_ptr=0.
